obi_protocol_monitor: RTL

//  Synthesizable, parametrised OBI manager-port compliance monitor for silicon/FPGA debug and UVM-less benches.

---
 rtl/obi_protocol_monitor_if.sv | 31 +++
 rtl/obi_protocol_monitor.sv | 135 +++++++++++++
 2 files changed

// File: rtl/obi_protocol_monitor_if.sv
// One OBI manager link: address/write channel plus response channel.
// A monitor modport exposes every signal read-only so taps can never drive the bus.
interface obi_protocol_monitor_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                      req;
    logic                      gnt;
    logic [ADDR_WIDTH-1:0]     addr;
    logic                      we;
    logic [DATA_WIDTH/8-1:0]   be;
    logic [DATA_WIDTH-1:0]     wdata;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      err;

    modport master (
        output req, addr, we, be, wdata, rready,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata, rready,
        output gnt, rvalid, rdata, err
    );

    modport monitor (
        input req, gnt, addr, we, be, wdata, rvalid, rready, rdata, err
    );
endinterface

// File: rtl/obi_protocol_monitor.sv
// OBI compliance monitor: handshake stability, R-5 ordering, overflow and response timeout checks.
// Flags/capture register one cycle after detection, irq one cycle later; passive, never back-pressures.
module obi_protocol_monitor #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 256,
    localparam int CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clear_i,
    obi_protocol_monitor_if.monitor     obi,
    output logic [CNT_WIDTH-1:0]        outstanding_o,
    output logic [6:0]                  violation_o,
    output logic                        first_valid_o,
    output logic [2:0]                  first_code_o,
    output logic [ADDR_WIDTH-1:0]       first_addr_o,
    output logic [31:0]                 first_time_o,
    output logic                        irq_o
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int TW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [TW-1:0]        T_MAX   = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]        T_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic                   prev_pend;
    logic                   prev_rsp_pend;
    logic [ADDR_WIDTH-1:0]  prev_addr;
    logic                   prev_we;
    logic [BE_WIDTH-1:0]    prev_be;
    logic [DATA_WIDTH-1:0]  prev_wdata;
    logic [DATA_WIDTH-1:0]  prev_rdata;
    logic                   prev_err;

    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [31:0]            cycle_cnt;

    logic                   acc, rsp, rsp_ok, cnt_zero, take;
    logic [6:0]             det;
    logic [2:0]             first_idx;

    assign outstanding_o = cnt_q;

    always_comb begin
        acc      = obi.req & obi.gnt;
        rsp      = obi.rvalid & obi.rready;
        cnt_zero = (cnt_q == '0);
        rsp_ok   = rsp & ~cnt_zero;

        det    = '0;
        det[0] = prev_pend & ~obi.req;
        det[1] = prev_pend & obi.req &
                 ({obi.addr, obi.we, obi.be} != {prev_addr, prev_we, prev_be});
        det[2] = prev_pend & obi.req & prev_we & (obi.wdata != prev_wdata);
        det[3] = prev_rsp_pend &
                 (~obi.rvalid | ({obi.rdata, obi.err} != {prev_rdata, prev_err}));
        // A grant in this same cycle does not make an early response legal.
        det[4] = obi.rvalid & cnt_zero;
        det[5] = acc & (cnt_q == CNT_MAX) & ~rsp_ok;

        cnt_d = cnt_q;
        if (acc & ~rsp_ok & (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else if (rsp_ok & ~acc) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end

        // Timer saturates so a single stall raises the timeout exactly once.
        timer_d = '0;
        if ((TIMEOUT_CYCLES != 0) && !rsp && !cnt_zero) begin
            timer_d = (timer_q == T_MAX) ? T_MAX : timer_q + TW'(1);
            det[6]  = (timer_q == T_LAST);
        end

        first_idx = '0;
        for (int i = 6; i >= 0; i--) begin
            if (det[i]) begin
                first_idx = 3'(i);
            end
        end

        take = (|det) & (~first_valid_o | clear_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_pend     <= 1'b0;
            prev_rsp_pend <= 1'b0;
            prev_addr     <= '0;
            prev_we       <= 1'b0;
            prev_be       <= '0;
            prev_wdata    <= '0;
            prev_rdata    <= '0;
            prev_err      <= 1'b0;
            cnt_q         <= '0;
            timer_q       <= '0;
            cycle_cnt     <= '0;
            violation_o   <= '0;
            irq_o         <= 1'b0;
            first_valid_o <= 1'b0;
            first_code_o  <= '0;
            first_addr_o  <= '0;
            first_time_o  <= '0;
        end else begin
            prev_pend     <= obi.req & ~obi.gnt;
            prev_rsp_pend <= obi.rvalid & ~obi.rready;
            prev_addr     <= obi.addr;
            prev_we       <= obi.we;
            prev_be       <= obi.be;
            prev_wdata    <= obi.wdata;
            prev_rdata    <= obi.rdata;
            prev_err      <= obi.err;
            cnt_q         <= cnt_d;
            timer_q       <= timer_d;
            cycle_cnt     <= cycle_cnt + 32'd1;
            // A violation coinciding with clear survives it.
            violation_o   <= (clear_i ? 7'd0 : violation_o) | det;
            irq_o         <= |violation_o;
            if (take) begin
                first_valid_o <= 1'b1;
                first_code_o  <= first_idx;
                first_addr_o  <= obi.addr;
                first_time_o  <= cycle_cnt;
            end else if (clear_i) begin
                first_valid_o <= 1'b0;
                first_code_o  <= '0;
                first_addr_o  <= '0;
                first_time_o  <= '0;
            end
        end
    end
endmodule
